// File: rtl/ir_rx_decoder.sv
// Pulse-width IR symbol decoder: synchronises rx_port, measures phase widths,
// classifies LEADER / DATA-1 / DATA-0 / STOP symbols and assembles a 32-bit payload.
module ir_rx_decoder #(
   parameter int BASE_DELAY = 250,
   parameter int TOL        = 60,
   parameter int LEADER_MIN = 8
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_port,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   output logic        rx_error,
   output logic        rx_busy
);

   localparam int SAT = 4*BASE_DELAY + TOL + 1;
   localparam int CW  = $clog2(SAT + 1);

   localparam logic [CW-1:0] P_SAT     = CW'(SAT);
   localparam logic [CW-1:0] P_ONE_LO  = CW'(BASE_DELAY - TOL);
   localparam logic [CW-1:0] P_ONE_HI  = CW'(BASE_DELAY + TOL);
   localparam logic [CW-1:0] P_LEAD_LO = CW'(2*BASE_DELAY - TOL);
   localparam logic [CW-1:0] P_LEAD_HI = CW'(2*BASE_DELAY + TOL);
   localparam logic [CW-1:0] P_ZERO_LO = CW'(3*BASE_DELAY - TOL);
   localparam logic [CW-1:0] P_ZERO_HI = CW'(3*BASE_DELAY + TOL);
   // r_cnt lags the phase length by one, so this marks 2B-TOL low cycles
   localparam logic [CW-1:0] P_STOP_M1 = CW'(2*BASE_DELAY - TOL - 1);
   localparam logic [5:0]    P_LMIN    = 6'(LEADER_MIN);

   typedef enum logic [2:0] {S_IDLE, S_LEADER, S_DATA, S_STOP, S_FAULT} state_t;
   typedef enum logic [1:0] {C_BAD, C_ONE, C_LEAD, C_ZERO} cls_t;

   logic          r_sync1, r_sync2, r_s_d;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   cls_t          r_hcls;
   logic [5:0]    r_lead;
   logic [5:0]    r_bits;
   logic [31:0]   r_shift;
   logic          r_first;
   logic [31:0]   r_data;
   logic          r_valid, r_error, r_busy;

   logic w_rise, w_fall, w_edge, w_ovf, w_is_bit;
   cls_t w_cls;

   assign w_rise   = r_sync2 & ~r_s_d;
   assign w_fall   = ~r_sync2 & r_s_d;
   assign w_edge   = w_rise | w_fall;
   assign w_ovf    = ~w_edge && (r_cnt > P_ZERO_HI);
   assign w_is_bit = (w_cls == C_ONE) || (w_cls == C_ZERO);

   always_comb begin
      w_cls = C_BAD;
      if (r_cnt >= P_ONE_LO && r_cnt <= P_ONE_HI)
         w_cls = C_ONE;
      else if (r_cnt >= P_LEAD_LO && r_cnt <= P_LEAD_HI)
         w_cls = C_LEAD;
      else if (r_cnt >= P_ZERO_LO && r_cnt <= P_ZERO_HI)
         w_cls = C_ZERO;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_s_d   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= rx_port;
         r_sync2 <= r_sync1;
         r_s_d   <= r_sync2;
         if (w_edge)
            r_cnt <= CW'(1);
         else if (r_cnt != P_SAT)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_hcls  <= C_BAD;
         r_lead  <= '0;
         r_bits  <= '0;
         r_shift <= '0;
         r_first <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_LEADER;
                  r_busy  <= 1'b1;
                  r_lead  <= '0;
                  r_bits  <= '0;
                  r_first <= 1'b1;
                  r_hcls  <= C_BAD;
               end
            end
            S_LEADER: begin
               if (w_ovf) begin
                  r_state <= S_FAULT;
                  r_error <= 1'b1;
               end else if (w_rise) begin
                  if (r_hcls == C_LEAD && w_cls == C_LEAD) begin
                     if (r_lead != 6'd33)
                        r_lead <= r_lead + 6'd1;
                  end else begin
                     r_state <= S_FAULT;
                     r_error <= 1'b1;
                  end
               end else if (w_fall) begin
                  r_first <= 1'b0;
                  if (w_cls == C_LEAD) begin
                     r_hcls <= C_LEAD;
                  end else if (w_is_bit && r_lead >= P_LMIN && r_lead <= 6'd32) begin
                     r_state <= S_DATA;
                     r_hcls  <= w_cls;
                     r_shift <= {r_shift[30:0], w_cls == C_ONE};
                     r_bits  <= 6'd1;
                  end else if (w_cls == C_BAD && r_first) begin
                     // a short blip on an idle line is noise, not a broken frame
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_FAULT;
                     r_error <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_ovf) begin
                  r_state <= S_FAULT;
                  r_error <= 1'b1;
               end else if (w_rise) begin
                  if (w_cls != r_hcls) begin
                     r_state <= S_FAULT;
                     r_error <= 1'b1;
                  end
               end else if (w_fall) begin
                  if (r_bits == 6'd32) begin
                     if (w_cls == C_LEAD) begin
                        r_state <= S_STOP;
                     end else begin
                        r_state <= S_FAULT;
                        r_error <= 1'b1;
                     end
                  end else if (w_is_bit) begin
                     r_hcls  <= w_cls;
                     r_shift <= {r_shift[30:0], w_cls == C_ONE};
                     r_bits  <= r_bits + 6'd1;
                  end else begin
                     r_state <= S_FAULT;
                     r_error <= 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (w_rise) begin
                  r_state <= S_FAULT;
                  r_error <= 1'b1;
               end else if (r_cnt == P_STOP_M1) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_FAULT: begin
               if (!r_sync2) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data  = r_data;
   assign rx_valid = r_valid;
   assign rx_error = r_error;
   assign rx_busy  = r_busy;

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Directed bench for ir_rx_decoder with a scaled symbol unit (B=20, TOL=5)
// so that full 32-bit frames stay short.
module tb_ir_rx_decoder;

   localparam int B  = 20;
   localparam int T  = 5;
   localparam int LM = 8;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_port = 1'b0;
   logic [31:0] rx_data;
   logic        rx_valid, rx_error, rx_busy;

   int errs   = 0;
   int checks = 0;
   int n_val  = 0;
   int n_err  = 0;
   logic [31:0] vq[$];

   ir_rx_decoder #(.BASE_DELAY(B), .TOL(T), .LEADER_MIN(LM)) dut (
      .clock(clock), .reset_n(reset_n), .rx_port(rx_port),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_busy(rx_busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (rx_valid) begin
         n_val++;
         vq.push_back(rx_data);
      end
      if (rx_error) n_err++;
   end

   task automatic ph(input logic lv, input int n);
      rx_port = lv;
      repeat (n) @(negedge clock);
   endtask

   task automatic sym(input int w);
      ph(1'b1, w);
      ph(1'b0, w);
   endtask

   task automatic send_bits(input logic [31:0] d, input int nb, input int w1);
      for (int i = 31; i > 31 - nb; i--) sym(d[i] ? w1 : 3*B);
   endtask

   task automatic send_frame(input logic [31:0] d, input int nlead, input int w1);
      repeat (nlead) sym(2*B);
      send_bits(d, 32, w1);
      sym(2*B);
   endtask

   task automatic test_reset;
      rx_port = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (rx_data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h want 0", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b want 0", rx_error); end
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
   endtask

   task automatic test_loopback;
      int v0, e0, k;
      v0 = n_val; e0 = n_err;
      rx_port = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL busy_early: got %b want 0", rx_busy); end
      @(negedge clock);
      checks++; if (rx_busy !== 1'b1) begin errs++; $display("FAIL busy_rise: got %b want 1", rx_busy); end
      ph(1'b1, 2*B - 3);
      ph(1'b0, 2*B);
      repeat (LM - 1) sym(2*B);
      send_bits(32'hBEEF0001, 32, B);
      ph(1'b1, 2*B);
      rx_port = 1'b0;
      k = -1;
      for (int i = 1; i <= 3*B && k < 0; i++) begin
         @(negedge clock);
         if (rx_valid) k = i;
      end
      checks++; if (k != 2*B - T + 2) begin errs++; $display("FAIL valid_latency: got %0d want %0d", k, 2*B - T + 2); end
      ph(1'b0, 10);
      checks++; if (n_val - v0 != 1) begin errs++; $display("FAIL loop_nvalid: got %0d want 1", n_val - v0); end
      checks++; if (rx_data !== 32'hBEEF0001) begin errs++; $display("FAIL loop_data: got %h want beef0001", rx_data); end
      checks++; if (n_err != e0) begin errs++; $display("FAIL loop_noerr: got %0d want 0", n_err - e0); end
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL loop_busy: got %b want 0", rx_busy); end
   endtask

   task automatic test_short_leader_bad;
      int v0, e0, k;
      v0 = n_val; e0 = n_err;
      repeat (5) sym(2*B);
      ph(1'b1, B);
      rx_port = 1'b0;
      k = -1;
      for (int i = 1; i <= 2*B && k < 0; i++) begin
         @(negedge clock);
         if (rx_error) k = i;
      end
      checks++; if (k != 3) begin errs++; $display("FAIL short_err_time: got %0d want 3", k); end
      ph(1'b0, 4*B);
      checks++; if (n_err - e0 != 1) begin errs++; $display("FAIL short_nerr: got %0d want 1", n_err - e0); end
      checks++; if (n_val != v0) begin errs++; $display("FAIL short_novalid: got %0d want 0", n_val - v0); end
      checks++; if (rx_data !== 32'hBEEF0001) begin errs++; $display("FAIL short_data_held: got %h want beef0001", rx_data); end
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL short_busy: got %b want 0", rx_busy); end
   endtask

   task automatic test_short_leader_ok;
      int v0, e0;
      v0 = n_val; e0 = n_err;
      send_frame(32'h0, 10, B);
      ph(1'b0, B);
      checks++; if (n_val - v0 != 1) begin errs++; $display("FAIL lead10_nvalid: got %0d want 1", n_val - v0); end
      checks++; if (rx_data !== 32'h0) begin errs++; $display("FAIL lead10_data: got %h want 0", rx_data); end
      checks++; if (n_err != e0) begin errs++; $display("FAIL lead10_noerr: got %0d want 0", n_err - e0); end
   endtask

   task automatic test_tolerance;
      int v0, e0;
      v0 = n_val; e0 = n_err;
      send_frame(32'h0000FFFF, LM, B - T);
      ph(1'b0, B);
      checks++; if (n_val - v0 != 1 || rx_data !== 32'h0000FFFF) begin errs++; $display("FAIL tol_low: got n=%0d data=%h want 1 0000ffff", n_val - v0, rx_data); end
      v0 = n_val;
      send_frame(32'hFFFF0000, LM, B + T);
      ph(1'b0, B);
      checks++; if (n_val - v0 != 1 || rx_data !== 32'hFFFF0000) begin errs++; $display("FAIL tol_high: got n=%0d data=%h want 1 ffff0000", n_val - v0, rx_data); end
      checks++; if (n_err != e0) begin errs++; $display("FAIL tol_noerr: got %0d want 0", n_err - e0); end
      v0 = n_val;
      repeat (LM) sym(2*B);
      ph(1'b1, B - T - 1);
      ph(1'b0, 4*B);
      checks++; if (n_err - e0 != 1) begin errs++; $display("FAIL tol_out_err: got %0d want 1", n_err - e0); end
      checks++; if (n_val != v0) begin errs++; $display("FAIL tol_out_novalid: got %0d want 0", n_val - v0); end
      v0 = n_val; e0 = n_err;
      ph(1'b1, 3);
      ph(1'b0, 2*B);
      checks++; if (n_val != v0 || n_err != e0) begin errs++; $display("FAIL glitch_strobe: got v=%0d e=%0d want 0 0", n_val - v0, n_err - e0); end
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      v0 = n_val; e0 = n_err;
      repeat (LM) sym(2*B);
      send_bits(32'hA5A5A5A5, 11, B);
      ph(1'b1, 10);
      reset_n = 1'b0;
      #1;
      checks++; if (rx_data !== 32'h0 || rx_valid !== 1'b0 || rx_error !== 1'b0 || rx_busy !== 1'b0) begin
         errs++; $display("FAIL midreset_outs: got d=%h v=%b e=%b b=%b want all 0", rx_data, rx_valid, rx_error, rx_busy); end
      rx_port = 1'b0;
      repeat (5) @(negedge clock);
      reset_n = 1'b1;
      ph(1'b0, 2*B);
      checks++; if (n_val != v0 || n_err != e0) begin errs++; $display("FAIL midreset_nostrobe: got v=%0d e=%0d want 0 0", n_val - v0, n_err - e0); end
      send_frame(32'hA5A5A5A5, LM, B);
      ph(1'b0, B);
      checks++; if (n_val - v0 != 1 || rx_data !== 32'hA5A5A5A5) begin errs++; $display("FAIL midreset_frame: got n=%0d data=%h want 1 a5a5a5a5", n_val - v0, rx_data); end
   endtask

   task automatic test_stuck;
      int v0, e0;
      v0 = n_val; e0 = n_err;
      repeat (LM) sym(2*B);
      send_bits(32'h13579BDF, 5, B);
      ph(1'b1, 2000);
      ph(1'b0, 4*B);
      checks++; if (n_err - e0 != 1) begin errs++; $display("FAIL stuck_nerr: got %0d want 1", n_err - e0); end
      checks++; if (n_val != v0) begin errs++; $display("FAIL stuck_novalid: got %0d want 0", n_val - v0); end
      checks++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL stuck_busy: got %b want 0", rx_busy); end
      send_frame(32'h13579BDF, LM, B);
      ph(1'b0, B);
      checks++; if (n_val - v0 != 1 || rx_data !== 32'h13579BDF) begin errs++; $display("FAIL stuck_recover: got n=%0d data=%h want 1 13579bdf", n_val - v0, rx_data); end
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      logic [31:0] d0, d1;
      v0 = n_val; e0 = n_err;
      send_frame(32'h12345678, LM, B);
      send_frame(32'hFFFFFFFF, LM, B);
      ph(1'b0, B);
      d0 = 32'hx; d1 = 32'hx;
      if (vq.size() >= 2) begin
         d0 = vq[vq.size() - 2];
         d1 = vq[vq.size() - 1];
      end
      checks++; if (n_val - v0 != 2) begin errs++; $display("FAIL b2b_nvalid: got %0d want 2", n_val - v0); end
      checks++; if (d0 !== 32'h12345678) begin errs++; $display("FAIL b2b_first: got %h want 12345678", d0); end
      checks++; if (d1 !== 32'hFFFFFFFF) begin errs++; $display("FAIL b2b_second: got %h want ffffffff", d1); end
      checks++; if (n_err != e0) begin errs++; $display("FAIL b2b_noerr: got %0d want 0", n_err - e0); end
   endtask

   initial begin
      test_reset;
      test_loopback;
      test_short_leader_bad;
      test_short_leader_ok;
      test_tolerance;
      test_reset_mid;
      test_stuck;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ir_rx_decoder.md
# ir_rx_decoder

Receive-side symbol decoder for the IR link. It consumes the pulse-width-encoded line produced by the `ir_transceiver` transmitter (`tx_port`, typically looped to `rx_port` or driven by the IR photodiode). It measures high and low phase widths, classifies each symbol as LEADER, DATA‑1, DATA‑0 or STOP, and assembles the 32-bit payload MSB first. It presents the payload with a one-cycle valid strobe or a one-cycle error strobe.

## Interface
- `BASE_DELAY`, default 250: base symbol unit in clocks.
  - LEADER/STOP phase = 2·BASE_DELAY.
  - DATA‑1 phase = BASE_DELAY.
  - DATA‑0 phase = 3·BASE_DELAY.
- `TOL`, default 60: ± tolerance in clocks on every phase width. Legal range is 0 < TOL < BASE_DELAY/2, which keeps the classes disjoint.
- `LEADER_MIN`, default 8: minimum leader symbols before data is accepted. Legal range 1..32.
- `clock` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Deassertion is synchronous to `clock`.
- `rx_port` input 1: raw IR line, asynchronous to `clock`.
- `rx_data` output 32: last successfully decoded payload; holds until the next valid frame.
- `rx_valid` output 1: one-cycle strobe when `rx_data` is updated.
- `rx_error` output 1: one-cycle strobe when a frame is aborted.
- `rx_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronisation:** `rx_port` passes through a 2-flop synchroniser. All edges and widths are measured on the synchronised signal `s`.
- **Phase counter:** counts cycles since the last edge of `s`. It restarts at 1 on the first cycle after each edge and saturates at 4·BASE_DELAY+TOL+1. Width is `$clog2` of that value.
- **Phase classes** (width w at the phase end):
  - ONE: |w − B| ≤ TOL.
  - LEAD: |w − 2B| ≤ TOL.
  - ZERO: |w − 3B| ≤ TOL.
  - Anything else: BAD.
- **Symbol rule:** a symbol is a high phase followed by a low phase. The low phase must fall in the same class as the preceding high phase; otherwise the symbol is BAD.
- **FSM states:** IDLE, LEADER, DATA, STOP, FAULT.
  - **IDLE:** a rising edge of `s` moves to LEADER and clears the leader count and bit count.
    - At the falling edge, if the high phase is BAD → silently return to IDLE. Glitches on an idle line are never errors.
  - **LEADER:** each complete LEAD symbol increments the leader count, which saturates at 33.
    - The first ONE/ZERO high phase moves to DATA, provided the leader count ≥ LEADER_MIN and ≤ 32. That bit is shifted in.
    - If the leader count < LEADER_MIN or = 33 at that point → FAULT.
  - **DATA:** each high phase classified ONE/ZERO shifts 1/0 into the LSB of the shift register. The symbol's low phase must match its class.
    - After 32 bits, the next high phase must be LEAD → STOP. Otherwise → FAULT.
  - **STOP:** when the low phase count reaches 2B−TOL, load `rx_data` with the shift register, pulse `rx_valid`, and go to IDLE.
    - A rising edge before that point → FAULT.
- **FAULT conditions:** any BAD phase inside LEADER, DATA or STOP, any class mismatch, or a phase count exceeding 3B+TOL.
  - Pulse `rx_error` for one cycle, then wait for `s` = 0 and go to IDLE.
  - Only one error pulse per fault, even if the line is stuck high.
- `rx_data` changes only on `rx_valid`.
- A new frame that starts immediately after STOP completes is decoded normally.
- **Reset (any time, including mid-frame):** state = IDLE, counters = 0, shift register = 0, synchroniser flops = 0, `rx_data` = 0, `rx_valid` = 0, `rx_error` = 0, `rx_busy` = 0. No strobe is emitted for the aborted frame.

## Timing
- Synchroniser latency is exactly 2 clocks.
- `rx_busy` rises 3 clocks after the `rx_port` rising edge that starts a frame.
- `rx_busy` falls in the cycle after `rx_valid` or after the return from FAULT to IDLE.
- Phase classification occurs in the cycle the opposite edge is seen on `s`.
- For a clean frame, `rx_valid` asserts 2B−TOL+2 clocks (±1) after the `rx_port` falling edge of the stop pulse. This is 442 ±1 clocks at the defaults, and always before the transmitter drops `tx_busy`.
- `rx_valid` and `rx_error` are never high in the same cycle. Each is high for exactly one clock.
- All outputs are registered.

## Test plan
- **Loopback with transmitter:** `ir_transceiver` `tx_port` → `rx_port`, `tx_data` = 0xBEEF0001.
  - Exactly one `rx_valid`, with `rx_data` = 0xBEEF0001.
  - `rx_error` stays 0.
  - `rx_busy` = 0 after `rx_valid`.
- **Short leader, accepted:** 10 leaders + data 0x00000000 + stop → `rx_valid`, `rx_data` = 0x00000000.
- **Short leader, rejected:** 5 leaders then a data symbol → one `rx_error` at that data pulse's falling edge, no `rx_valid`, `rx_data` unchanged.
- **Tolerance bounds:** DATA‑1 symbols with 190/190 and 310/310 phases are accepted. A 189-clock high phase → `rx_error`. A 3-clock glitch in IDLE → no strobe, `rx_busy` back to 0.
- **Reset mid-frame:** assert `reset_n` during bit 12.
  - All outputs 0 within the reset assertion, with no strobe.
  - After release, frame 0xA5A5A5A5 decodes correctly.
- **Stuck line and back-to-back frames:**
  - `rx_port` held high for 2000 clocks mid-frame → exactly one `rx_error`; recovery on the next clean frame.
  - Back-to-back frames 0x12345678, 0xFFFFFFFF → two `rx_valid` strobes with the correct data.
